// File: rtl/gf180mcu_fd_sc_mcu9t5v0__debrx_pkg.sv
// Shared types for the debounce receiver: FSM state encoding and
// the end-to-end latency helper.
package gf180mcu_fd_sc_mcu9t5v0__debrx_pkg;

  typedef enum logic [1:0] {
    ST_LO,
    ST_QHI,
    ST_HI,
    ST_QLO
  } deb_state_e;

  function automatic int unsigned deb_latency(
    input int unsigned sync_stages,
    input int unsigned filt_cyc
  );
    return sync_stages + filt_cyc;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sync_chain.sv
// Multi-flop synchronizer for a single asynchronous line.
// All stages clear to 0 on reset.
module gf180mcu_fd_sc_mcu9t5v0__sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RN,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], D};
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign Q = sync_q[STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__debrx_4.sv
// Debounce receiver: synchronizes I, qualifies each level change for
// FILT_CYC cycles, and reports the accepted level with edge pulses.
module gf180mcu_fd_sc_mcu9t5v0__debrx_4
  import gf180mcu_fd_sc_mcu9t5v0__debrx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic CLK,
  input  logic RN,
  input  logic I,
  input  logic EN,
  output logic Z,
  output logic ZR,
  output logic ZF
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic s;

  gf180mcu_fd_sc_mcu9t5v0__sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .CLK(CLK),
    .RN (RN),
    .D  (I),
    .Q  (s)
  );

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             zr_q, zr_d;
  logic             zf_q, zf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    zr_d    = 1'b0;
    zf_d    = 1'b0;
    unique case (state_q)
      ST_LO: begin
        if (EN && s) begin
          if (FILT_CYC == 1) begin
            state_d = ST_HI;
            z_d     = 1'b1;
            zr_d    = 1'b1;
          end else begin
            state_d = ST_QHI;
            cnt_d   = ONE;
          end
        end
      end
      ST_QHI: begin
        // a reversal or disable beats completion in the same cycle
        if (!EN || !s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_HI;
          cnt_d   = '0;
          z_d     = 1'b1;
          zr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_HI: begin
        if (EN && !s) begin
          if (FILT_CYC == 1) begin
            state_d = ST_LO;
            z_d     = 1'b0;
            zf_d    = 1'b1;
          end else begin
            state_d = ST_QLO;
            cnt_d   = ONE;
          end
        end
      end
      ST_QLO: begin
        if (!EN || s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_LO;
          cnt_d   = '0;
          z_d     = 1'b0;
          zf_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      zr_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      zr_q    <= zr_d;
      zf_q    <= zf_d;
    end
  end

  assign Z  = z_q;
  assign ZR = zr_q;
  assign ZF = zf_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__debrx_4.md
GF180MCU_FD_SC_MCU9T5V0__DEBRX_4 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__debrx_4

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on I; legal range 2..4.
REQ-002 Parameter FILT_CYC, default 4: consecutive synchronized cycles needed to accept a level change; legal range 1..255.
REQ-003 Parameter CNT_W, default 8: qualification counter width; SHALL satisfy 2**CNT_W > FILT_CYC.
REQ-004 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port RN, input, 1: asynchronous active-low reset.
REQ-006 Port I, input, 1: asynchronous, buffered line driven from another domain or a pad.
REQ-007 Port EN, input, 1: filter enable; 0 freezes the accepted level.
REQ-008 Port Z, output, 1: filtered, accepted level of I.
REQ-009 Port ZR, output, 1: one-cycle pulse on an accepted 0->1 change of Z.
REQ-010 Port ZF, output, 1: one-cycle pulse on an accepted 1->0 change of Z.

Function
REQ-011 I SHALL pass through SYNC_STAGES flops; the last stage output is S, and only S feeds the FSM.
REQ-012 The FSM SHALL have four states: LO (Z=0), QHI (Z=0, qualifying high), HI (Z=1), QLO (Z=1, qualifying low).
REQ-013 LO: S=1 with EN=1 -> QHI with cnt=1. When FILT_CYC=1, it goes directly to HI.
REQ-014 QHI: S=0 -> LO, cnt=0; S=1 and cnt==FILT_CYC-1 -> HI; otherwise cnt+1.
REQ-015 HI and QLO SHALL mirror REQ-013 and REQ-014 with the polarity of S inverted.
REQ-016 Z, ZR and ZF SHALL be registered outputs, with no combinational path from any input.
REQ-017 ZR (ZF) SHALL be 1 only in the cycle in which Z first shows 1 (0), and 0 otherwise.
REQ-018 Latency: for a clean, held input change, Z SHALL change exactly SYNC_STAGES+FILT_CYC rising edges after the first edge that samples the new I level.
REQ-019 A pulse on S shorter than FILT_CYC cycles SHALL produce no change on Z and no ZR or ZF pulse.
REQ-020 EN=0 SHALL force QHI->LO and QLO->HI and clear cnt; LO and HI are held, the synchronizer keeps running, and ZR=ZF=0.
REQ-021 When EN returns to 1, qualification SHALL restart from cnt=0 using the current S.
REQ-022 In the same cycle, an S reversal has priority over counter completion; completion is evaluated only when S matches the qualifying level.
REQ-023 cnt SHALL never wrap; it saturates at FILT_CYC-1 by construction of REQ-014.

Reset
REQ-024 RN=0 SHALL immediately, without waiting for CLK, set all synchronizer flops to 0, the state to LO, cnt to 0, and Z, ZR and ZF to 0.
REQ-025 Reset deassertion SHALL take effect on the first rising CLK edge after RN returns to 1.
REQ-026 If I=1 at reset release, Z SHALL rise following REQ-018, with a ZR pulse.
REQ-027 Reset asserted mid-qualification SHALL discard the qualification and produce no ZR or ZF pulse.

Structure
REQ-028 Package gf180mcu_fd_sc_mcu9t5v0__debrx_pkg SHALL hold the four-state FSM enum typedef and the latency function SYNC_STAGES+FILT_CYC.
REQ-029 The synchronizer SHALL be a separate sub-module, gf180mcu_fd_sc_mcu9t5v0__sync_chain, parameterized by stage count, with CLK and RN ports.
REQ-030 The FSM and counter SHALL live in the top module; there SHALL be no other hierarchy.

Verification (SYNC_STAGES=2, FILT_CYC=4)
REQ-031 Release RN with I=0 and EN=1, then run 20 cycles -> Z=ZR=ZF=0 throughout.
REQ-032 Step I 0->1 and hold, with EN=1 -> Z=1 on edge 6 after the first sampled 1, ZR=1 for exactly that cycle, and ZF=0.
REQ-033 Apply a 3-cycle I=1 glitch from LO -> Z, ZR and ZF stay 0; a 4-cycle pulse -> Z=1 for at least one cycle with a single ZR pulse.
REQ-034 From HI, step I 1->0 and hold -> Z=0 on edge 6 with a single ZF pulse.
REQ-035 Hold I=1, drop EN after 2 qualifying cycles, and re-raise it 3 cycles later -> Z stays 0 while EN=0, then rises 4 edges after EN=1.
REQ-036 Assert RN asynchronously (mid-cycle) while in HI -> Z goes to 0 before the next CLK edge, with no ZF pulse.
